regfile_sb: RTL and testbench

Parametrised LC-3 general-purpose register file, successor to the fixed 8×16 design. It provides one write port, two combinational read ports, and LC-3 N/Z/P condition codes that update on every register write. A per-register pending-write scoreboard lets the control unit / pipeline front end stall on read-after-write hazards. It sits between the decode stage (SR1/SR2/DR fields) and the shared `Buss`.

---
 rtl/regfile_sb.sv | 92 +++++++++
 tb/tb_regfile_sb.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// LC-3 register file: 1 write / 2 combinational reads, N/Z/P codes, pending-write scoreboard.
// Optional same-cycle write-to-read bypass when REGFILE_BYPASS_EN is defined.
module regfile_sb_entry #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic              rsv,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q,
   output logic              pend
);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q    <= '0;
         pend <= 1'b0;
      end else begin
         if (we) q <= d;
         // A reserve on the same edge as the write means a new producer issued
         if (rsv)     pend <= 1'b1;
         else if (we) pend <= 1'b0;
      end
   end
endmodule

module regfile_sb #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              regWE,
   input  logic [ADDR_W-1:0] DR,
   input  logic [DATA_W-1:0] Buss,
   input  logic [ADDR_W-1:0] SR1,
   input  logic [ADDR_W-1:0] SR2,
   output logic [DATA_W-1:0] Ra,
   output logic [DATA_W-1:0] Rb,
   input  logic              rsvWE,
   input  logic [ADDR_W-1:0] rsvDR,
   output logic              busy1,
   output logic              busy2,
   output logic              allIdle,
   output logic [2:0]        nzp
);
   localparam int NUM_REGS = 2**ADDR_W;

   logic [NUM_REGS-1:0][DATA_W-1:0] r;
   logic [NUM_REGS-1:0]             pend;

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      regfile_sb_entry #(.DATA_W(DATA_W)) u_ent (
         .clk  (clk),
         .reset(reset),
         .we   (regWE && (DR == ADDR_W'(i))),
         .rsv  (rsvWE && (rsvDR == ADDR_W'(i))),
         .d    (Buss),
         .q    (r[i]),
         .pend (pend[i])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)              nzp <= 3'b010;
      else if (regWE) begin
         if (Buss[DATA_W-1])   nzp <= 3'b100;
         else if (Buss == '0)  nzp <= 3'b010;
         else                  nzp <= 3'b001;
      end
   end

   assign allIdle = ~|pend;

`ifdef REGFILE_BYPASS_EN
   logic byp1, byp2, rsv1, rsv2;
   assign byp1  = regWE && (DR == SR1);
   assign byp2  = regWE && (DR == SR2);
   assign rsv1  = rsvWE && (rsvDR == SR1);
   assign rsv2  = rsvWE && (rsvDR == SR2);
   assign Ra    = byp1 ? Buss : r[SR1];
   assign Rb    = byp2 ? Buss : r[SR2];
   // The in-flight write retires the pending bit unless a new producer reserves it
   assign busy1 = pend[SR1] & ~(byp1 & ~rsv1);
   assign busy2 = pend[SR2] & ~(byp2 & ~rsv2);
`else
   assign Ra    = r[SR1];
   assign Rb    = r[SR2];
   assign busy1 = pend[SR1];
   assign busy2 = pend[SR2];
`endif
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default 16x8 instance plus a 32x16 instance.
module tb_regfile_sb;
   logic        clk = 1'b0;
   logic        reset;
   logic        regWE, rsvWE, busy1, busy2, allIdle;
   logic [2:0]  DR, SR1, SR2, rsvDR, nzp;
   logic [15:0] Buss, Ra, Rb;

   logic        w_regWE, w_rsvWE, w_busy1, w_busy2, w_allIdle;
   logic [3:0]  w_DR, w_SR1, w_SR2, w_rsvDR;
   logic [2:0]  w_nzp;
   logic [31:0] w_Buss, w_Ra, w_Rb;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   regfile_sb dut (
      .clk(clk), .reset(reset), .regWE(regWE), .DR(DR), .Buss(Buss),
      .SR1(SR1), .SR2(SR2), .Ra(Ra), .Rb(Rb), .rsvWE(rsvWE), .rsvDR(rsvDR),
      .busy1(busy1), .busy2(busy2), .allIdle(allIdle), .nzp(nzp)
   );

   regfile_sb #(.DATA_W(32), .ADDR_W(4)) dut_w (
      .clk(clk), .reset(reset), .regWE(w_regWE), .DR(w_DR), .Buss(w_Buss),
      .SR1(w_SR1), .SR2(w_SR2), .Ra(w_Ra), .Rb(w_Rb), .rsvWE(w_rsvWE), .rsvDR(w_rsvDR),
      .busy1(w_busy1), .busy2(w_busy2), .allIdle(w_allIdle), .nzp(w_nzp)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b0; regWE = 0; rsvWE = 0; DR = 0; rsvDR = 0; Buss = 0; SR1 = 0; SR2 = 0;
      w_regWE = 0; w_rsvWE = 0; w_DR = 0; w_rsvDR = 0; w_Buss = 0; w_SR1 = 0; w_SR2 = 0;
      tick;
      reset = 1'b1;
      regWE = 1; DR = 3; Buss = 16'h1234; rsvWE = 1; rsvDR = 3;
      tick;
      regWE = 0; rsvWE = 0; SR1 = 3;
      #1;
      total++; if (Ra !== 16'h1234) $display("FAIL pre_reset_ra got %h exp 1234", Ra); else passed++;
      total++; if (busy1 !== 1'b1) $display("FAIL pre_reset_busy1 got %b exp 1", busy1); else passed++;
      total++; if (nzp !== 3'b001) $display("FAIL pre_reset_nzp got %b exp 001", nzp); else passed++;
      #1 reset = 1'b0;
      #1;
      total++; if (Ra !== 16'h0000) $display("FAIL reset_ra got %h exp 0000", Ra); else passed++;
      total++; if (busy1 !== 1'b0) $display("FAIL reset_busy1 got %b exp 0", busy1); else passed++;
      total++; if (allIdle !== 1'b1) $display("FAIL reset_allidle got %b exp 1", allIdle); else passed++;
      total++; if (nzp !== 3'b010) $display("FAIL reset_nzp got %b exp 010", nzp); else passed++;
      tick;
      reset = 1'b1;
   endtask

   task automatic test_write_read;
      for (int i = 0; i < 8; i++) begin
         regWE = 1; DR = 3'(i); Buss = 16'hA0A0 + 16'(i);
         tick;
      end
      regWE = 0;
      total++; if (nzp !== 3'b100) $display("FAIL wr_nzp got %b exp 100", nzp); else passed++;
      for (int i = 0; i < 8; i++) begin
         SR1 = 3'(i); SR2 = 3'(7 - i);
         #1;
         total++; if (Ra !== 16'hA0A0 + 16'(i)) $display("FAIL rd_ra[%0d] got %h exp %h", i, Ra, 16'hA0A0 + 16'(i)); else passed++;
         total++; if (Rb !== 16'hA0A0 + 16'(7 - i)) $display("FAIL rd_rb[%0d] got %h exp %h", i, Rb, 16'hA0A0 + 16'(7 - i)); else passed++;
      end
      SR1 = 4; SR2 = 4;
      #1;
      total++; if (Ra !== 16'hA0A4 || Rb !== 16'hA0A4) $display("FAIL same_sr got %h/%h exp a0a4/a0a4", Ra, Rb); else passed++;
   endtask

   task automatic test_nzp;
      regWE = 1; DR = 0; Buss = 16'h8000; tick;
      total++; if (nzp !== 3'b100) $display("FAIL nzp_neg got %b exp 100", nzp); else passed++;
      Buss = 16'h0000; tick;
      total++; if (nzp !== 3'b010) $display("FAIL nzp_zero got %b exp 010", nzp); else passed++;
      Buss = 16'h7FFF; tick;
      total++; if (nzp !== 3'b001) $display("FAIL nzp_pos got %b exp 001", nzp); else passed++;
      regWE = 0; Buss = 16'h0000; tick;
      total++; if (nzp !== 3'b001) $display("FAIL nzp_hold got %b exp 001", nzp); else passed++;
   endtask

   task automatic test_scoreboard;
      rsvWE = 1; rsvDR = 5; tick; rsvWE = 0;
      SR1 = 5; #1;
      total++; if (busy1 !== 1'b1) $display("FAIL rsv5_busy1 got %b exp 1", busy1); else passed++;
      total++; if (allIdle !== 1'b0) $display("FAIL rsv5_allidle got %b exp 0", allIdle); else passed++;
      regWE = 1; DR = 5; Buss = 16'h0055; tick; regWE = 0;
      total++; if (busy1 !== 1'b0) $display("FAIL wr5_busy1 got %b exp 0", busy1); else passed++;
      total++; if (allIdle !== 1'b1) $display("FAIL wr5_allidle got %b exp 1", allIdle); else passed++;
      rsvWE = 1; rsvDR = 2; regWE = 1; DR = 2; Buss = 16'h0022; tick;
      rsvWE = 0; regWE = 0; SR1 = 2; #1;
      total++; if (busy1 !== 1'b1) $display("FAIL same_edge_busy got %b exp 1", busy1); else passed++;
      rsvWE = 1; rsvDR = 2; tick; rsvWE = 0;
      total++; if (busy1 !== 1'b1) $display("FAIL rersv_busy got %b exp 1", busy1); else passed++;
      rsvWE = 1; rsvDR = 4; tick; rsvWE = 0;
      rsvWE = 1; rsvDR = 1; regWE = 1; DR = 4; Buss = 16'h0044; tick;
      rsvWE = 0; regWE = 0; SR1 = 1; SR2 = 4; #1;
      total++; if (busy1 !== 1'b1) $display("FAIL split_busy1 got %b exp 1", busy1); else passed++;
      total++; if (busy2 !== 1'b0) $display("FAIL split_busy2 got %b exp 0", busy2); else passed++;
      regWE = 1; DR = 2; tick; DR = 1; tick; regWE = 0;
      total++; if (allIdle !== 1'b1) $display("FAIL drain_allidle got %b exp 1", allIdle); else passed++;
   endtask

   task automatic test_bypass;
      logic [15:0] exp_rb;
      logic        exp_busy;
`ifdef REGFILE_BYPASS_EN
      exp_rb = 16'hBEEF; exp_busy = 1'b0;
`else
      exp_rb = 16'h0001; exp_busy = 1'b1;
`endif
      regWE = 1; DR = 6; Buss = 16'h0001; tick; regWE = 0;
      rsvWE = 1; rsvDR = 6; tick; rsvWE = 0;
      SR2 = 6; regWE = 1; DR = 6; Buss = 16'hBEEF; #1;
      total++; if (Rb !== exp_rb) $display("FAIL byp_rb got %h exp %h", Rb, exp_rb); else passed++;
      total++; if (busy2 !== exp_busy) $display("FAIL byp_busy2 got %b exp %b", busy2, exp_busy); else passed++;
      tick; regWE = 0; Buss = 16'h0000; #1;
      total++; if (Rb !== 16'hBEEF) $display("FAIL post_byp_rb got %h exp beef", Rb); else passed++;
      total++; if (busy2 !== 1'b0) $display("FAIL post_byp_busy2 got %b exp 0", busy2); else passed++;
   endtask

   task automatic test_param;
      w_regWE = 1; w_DR = 15; w_Buss = 32'h8000_0000; tick; w_regWE = 0;
      w_SR1 = 15; w_SR2 = 7; #1;
      total++; if (w_nzp !== 3'b100) $display("FAIL w_nzp got %b exp 100", w_nzp); else passed++;
      total++; if (w_Ra !== 32'h8000_0000) $display("FAIL w_ra got %h exp 80000000", w_Ra); else passed++;
      total++; if (w_Rb !== 32'h0) $display("FAIL w_rb7 got %h exp 00000000", w_Rb); else passed++;
      w_rsvWE = 1; w_rsvDR = 15; tick; w_rsvWE = 0;
      total++; if (w_busy1 !== 1'b1 || w_busy2 !== 1'b0) $display("FAIL w_rsv15 got %b%b exp 10", w_busy1, w_busy2); else passed++;
      w_rsvWE = 1; w_rsvDR = 7; w_regWE = 1; w_DR = 15; w_Buss = 32'h0000_0001; tick;
      w_rsvWE = 0; w_regWE = 0;
      total++; if (w_busy1 !== 1'b0 || w_busy2 !== 1'b1) $display("FAIL w_swap got %b%b exp 01", w_busy1, w_busy2); else passed++;
      total++; if (w_nzp !== 3'b001) $display("FAIL w_nzp_pos got %b exp 001", w_nzp); else passed++;
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_nzp;
      test_scoreboard;
      test_bypass;
      test_param;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
